// File: rtl/dp_ram_param.sv
// Parametrised true dual-port synchronous RAM with post-reset clear sequencer.
// Latency: read data 1 cycle after the request (2 cycles with DP_RAM_OUT_REG_EN defined).
// Backpressure: none; both ports are always accepted once init_done is high, inputs ignored during clear.
//
// Optional feature macro: DP_RAM_OUT_REG_EN adds one output register stage per port
// and delays collision by one cycle to keep it aligned with q_a/q_b.
//
// Ports:
//   clk, rst               clock (rising edge) and synchronous active-high reset
//   en_a, we_a, addr_a,    port A enable, write enable, address, write data
//   data_a, q_a            and registered read data
//   en_b ... q_b           port B, identical to port A
//   init_done              high once the clear sequence has finished
//   collision              registered pulse: both ports wrote the same address

module dp_ram_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  init_done,
  output logic                  collision
);

  // One extra bit so DEPTH = 2**ADDR_WIDTH can be represented without wrap.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH-1);

  typedef enum logic {INIT, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  live;
  logic                  in_a, in_b;
  logic                  wr_a, wr_b;
  logic                  col_evt;
  logic [DATA_WIDTH-1:0] rd_nxt_a, rd_nxt_b;
  logic [DATA_WIDTH-1:0] q1_a, q1_b;
  logic                  col1;

  assign live = (state_q == READY);
  assign in_a = ({1'b0, addr_a} < DEPTH_W);
  assign in_b = ({1'b0, addr_b} < DEPTH_W);
  assign wr_a = live && en_a && we_a && in_a;
  assign wr_b = live && en_b && we_b && in_b;
  assign col_evt = wr_a && wr_b && (addr_a == addr_b);

  assign init_done = live;

  // ---------------- clear sequencer FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (cnt_q == LAST_W) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // ---------------- storage ----------------
  // Port B is written first so a same-address port A write overrides it.
  // Memory is deliberately left untouched while rst is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
      end else begin
        if (wr_b) mem[addr_b] <= data_b;
        if (wr_a) mem[addr_a] <= data_a;
      end
    end
  end

  // Array reads here see pre-edge contents, which gives read-first behaviour
  // for both same-port and cross-port accesses; write-first substitutes the
  // port's own write data.
  always_comb begin
    rd_nxt_a = '0;
    if (in_a) begin
      if (we_a && (RDW_MODE == 1)) rd_nxt_a = data_a;
      else                         rd_nxt_a = mem[addr_a];
    end
  end

  always_comb begin
    rd_nxt_b = '0;
    if (in_b) begin
      if (we_b && (RDW_MODE == 1)) rd_nxt_b = data_b;
      else                         rd_nxt_b = mem[addr_b];
    end
  end

  // ---------------- output stage 1 ----------------
  always_ff @(posedge clk) begin
    if (rst || !live) begin
      q1_a <= '0;
      q1_b <= '0;
      col1 <= 1'b0;
    end else begin
      if (en_a) q1_a <= rd_nxt_a;
      if (en_b) q1_b <= rd_nxt_b;
      col1 <= col_evt;
    end
  end

`ifdef DP_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] q2_a, q2_b;
  logic                  col2;

  // Second stage follows stage 1 every cycle; holding is done in stage 1.
  always_ff @(posedge clk) begin
    if (rst || !live) begin
      q2_a <= '0;
      q2_b <= '0;
      col2 <= 1'b0;
    end else begin
      q2_a <= q1_a;
      q2_b <= q1_b;
      col2 <= col1;
    end
  end

  assign q_a       = q2_a;
  assign q_b       = q2_b;
  assign collision = col2;
`else
  assign q_a       = q1_a;
  assign q_b       = q1_b;
  assign collision = col1;
`endif

endmodule
